// File: rtl/i2c_slave_regs.sv
// I2C target bridging an external controller to a local 8-bit register bank through strobes.
// Define I2C_SLAVE_AUTOINC_EN to advance the register pointer after every written or ACKed read byte.
module i2c_slave_regs #(
    parameter logic [6:0] DEVICE_ADDR = 7'h50,
    parameter int         REG_WIDTH   = 8,
    parameter int         DATA_WIDTH  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    inout  wire                   io_scl,
    inout  wire                   io_sda,
    output logic [REG_WIDTH-1:0]  o_reg_addr,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    output logic                  o_wr_en,
    output logic                  o_rd_en,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    output logic                  o_busy
);

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        REG,
        REG_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        WAIT_STOP
    } state_t;

    state_t     state;
    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_prev;
    logic       sda_prev;
    logic [3:0] bit_count;
    logic [7:0] shift;
    logic       rw;
    logic       sda_low;

    logic       scl_s;
    logic       sda_s;
    logic       scl_rise;
    logic       scl_fall;
    logic       start_det;
    logic       stop_det;
    logic [7:0] rx_byte;

    assign io_scl = 1'bz;
    assign io_sda = sda_low ? 1'b0 : 1'bz;

    assign scl_s     = scl_sync[1];
    assign sda_s     = sda_sync[1];
    assign scl_rise  = scl_s & ~scl_prev;
    assign scl_fall  = ~scl_s & scl_prev;
    assign start_det = scl_s & scl_prev & sda_prev & ~sda_s;
    assign stop_det  = scl_s & scl_prev & ~sda_prev & sda_s;
    assign rx_byte   = {shift[6:0], sda_s};

    // Synchronizers reset to the idle-bus level so reset release never fakes an edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], io_scl};
            sda_sync <= {sda_sync[0], io_sda};
            scl_prev <= scl_s;
            sda_prev <= sda_s;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            bit_count  <= 4'd0;
            shift      <= 8'd0;
            rw         <= 1'b0;
            sda_low    <= 1'b0;
            o_reg_addr <= '0;
            o_wr_data  <= '0;
            o_wr_en    <= 1'b0;
            o_rd_en    <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            o_wr_en <= 1'b0;
            o_rd_en <= 1'b0;
`ifdef I2C_SLAVE_AUTOINC_EN
            // Advance after the strobe cycle so the strobe itself carries the old pointer.
            if (o_wr_en)
                o_reg_addr <= o_reg_addr + 1'b1;
`endif
            if (start_det) begin
                state     <= ADDR;
                bit_count <= 4'd0;
                sda_low   <= 1'b0;
            end else if (stop_det) begin
                state   <= IDLE;
                sda_low <= 1'b0;
                o_busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE, WAIT_STOP: sda_low <= 1'b0;
                    ADDR: begin
                        if (scl_rise) begin
                            shift <= rx_byte;
                            if (bit_count == 4'd7) begin
                                bit_count <= 4'd0;
                                if (rx_byte[7:1] == DEVICE_ADDR) begin
                                    state  <= ADDR_ACK;
                                    o_busy <= 1'b1;
                                    rw     <= rx_byte[0];
                                end else begin
                                    state  <= WAIT_STOP;
                                    o_busy <= 1'b0;
                                end
                            end else begin
                                bit_count <= bit_count + 4'd1;
                            end
                        end
                    end
                    // ACK slots: first fall asserts the ACK, second fall ends it.
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!sda_low) begin
                                sda_low <= 1'b1;
                            end else if (rw) begin
                                state     <= RDATA;
                                o_rd_en   <= 1'b1;
                                shift     <= i_rd_data;
                                sda_low   <= ~i_rd_data[7];
                                bit_count <= 4'd1;
                            end else begin
                                state   <= REG;
                                sda_low <= 1'b0;
                            end
                        end
                    end
                    REG: begin
                        if (scl_rise) begin
                            shift <= rx_byte;
                            if (bit_count == 4'd7) begin
                                bit_count  <= 4'd0;
                                o_reg_addr <= rx_byte;
                                state      <= REG_ACK;
                            end else begin
                                bit_count <= bit_count + 4'd1;
                            end
                        end
                    end
                    REG_ACK, WDATA_ACK: begin
                        if (scl_fall) begin
                            if (!sda_low) begin
                                sda_low <= 1'b1;
                            end else begin
                                sda_low <= 1'b0;
                                state   <= WDATA;
                            end
                        end
                    end
                    WDATA: begin
                        if (scl_rise) begin
                            shift <= rx_byte;
                            if (bit_count == 4'd7) begin
                                bit_count <= 4'd0;
                                o_wr_data <= rx_byte;
                                o_wr_en   <= 1'b1;
                                state     <= WDATA_ACK;
                            end else begin
                                bit_count <= bit_count + 4'd1;
                            end
                        end
                    end
                    // bit_count counts bits already placed on SDA; zero means reload first.
                    RDATA: begin
                        if (scl_fall) begin
                            if (bit_count == 4'd0) begin
                                o_rd_en   <= 1'b1;
                                shift     <= i_rd_data;
                                sda_low   <= ~i_rd_data[7];
                                bit_count <= 4'd1;
                            end else if (bit_count == 4'd8) begin
                                sda_low <= 1'b0;
                                state   <= RDATA_ACK;
                            end else begin
                                sda_low   <= ~shift[6];
                                shift     <= {shift[6:0], 1'b0};
                                bit_count <= bit_count + 4'd1;
                            end
                        end
                    end
                    RDATA_ACK: begin
                        if (scl_rise) begin
                            if (!sda_s) begin
                                state     <= RDATA;
                                bit_count <= 4'd0;
`ifdef I2C_SLAVE_AUTOINC_EN
                                o_reg_addr <= o_reg_addr + 1'b1;
`endif
                            end else begin
                                state <= WAIT_STOP;
                            end
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        sda_low <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bit-banged I2C controller driving i2c_slave_regs, checked against a register-bank model.
module tb_i2c_slave_regs;

    localparam logic [6:0] DEV = 7'h50;
    localparam int Q = 8;
`ifdef I2C_SLAVE_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic m_scl_low = 1'b0;
    logic m_sda_low = 1'b0;
    wire  scl_bus;
    wire  sda_bus;

    assign scl_bus = m_scl_low ? 1'b0 : 1'bz;
    assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
    pullup (scl_bus);
    pullup (sda_bus);

    logic [7:0] reg_addr;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic       wr_en;
    logic       rd_en;
    logic       busy;

    i2c_slave_regs #(.DEVICE_ADDR(DEV)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .io_scl     (scl_bus),
        .io_sda     (sda_bus),
        .o_reg_addr (reg_addr),
        .o_wr_data  (wr_data),
        .o_wr_en    (wr_en),
        .o_rd_en    (rd_en),
        .i_rd_data  (rd_data),
        .o_busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input logic [7:0] a);
        return a ^ 8'h08;
    endfunction

    // Register file behind the strobe interface.
    logic [7:0]   bank [256];
    logic [255:0] bank_written = '0;
    logic [7:0]   act_wr_a [256];
    logic [7:0]   act_wr_d [256];
    int           act_wr_n = 0;
    int           rd_n = 0;
    int           dut_low_n = 0;

    assign rd_data = bank_written[reg_addr] ? bank[reg_addr] : init_val(reg_addr);

    always @(negedge clk) begin
        if (wr_en) begin
            act_wr_a[act_wr_n & 255] <= reg_addr;
            act_wr_d[act_wr_n & 255] <= wr_data;
            act_wr_n                 <= act_wr_n + 1;
            bank[reg_addr]           <= wr_data;
            bank_written[reg_addr]   <= 1'b1;
        end
        if (rd_en)
            rd_n <= rd_n + 1;
        if (sda_bus === 1'b0 && !m_sda_low)
            dut_low_n <= dut_low_n + 1;
    end

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] model_mem [256];
    logic [7:0] wbuf [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        m_sda_low = 1'b0;
        m_scl_low = 1'b0;
        wait_clk(Q);
        m_sda_low = 1'b1;
        wait_clk(Q);
        m_scl_low = 1'b1;
    endtask

    task automatic bus_rstart();
        m_sda_low = 1'b0;
        wait_clk(Q);
        m_scl_low = 1'b0;
        wait_clk(Q);
        m_sda_low = 1'b1;
        wait_clk(Q);
        m_scl_low = 1'b1;
    endtask

    task automatic bus_stop();
        m_sda_low = 1'b1;
        wait_clk(Q);
        m_scl_low = 1'b0;
        wait_clk(Q);
        m_sda_low = 1'b0;
        wait_clk(2 * Q);
    endtask

    task automatic write_bit(input logic b);
        m_sda_low = ~b;
        wait_clk(Q);
        m_scl_low = 1'b0;
        wait_clk(2 * Q);
        m_scl_low = 1'b1;
    endtask

    task automatic read_bit(output logic b);
        m_sda_low = 1'b0;
        wait_clk(Q);
        m_scl_low = 1'b0;
        wait_clk(Q);
        b = sda_bus;
        wait_clk(Q);
        m_scl_low = 1'b1;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--)
            write_bit(d[i]);
        read_bit(b);
        ack = ~b;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(~ack);
    endtask

    task automatic i2c_write(input logic [6:0] dev, input logic [7:0] ra, input int n);
        logic       ack;
        logic       match;
        logic [7:0] p;
        logic [7:0] exp_a [4];
        logic [7:0] exp_d [4];
        int         wr0;
        int         low0;
        int         got;
        match = (dev == DEV);
        wr0   = act_wr_n;
        low0  = dut_low_n;
        p     = ra;
        bus_start();
        write_byte({dev, 1'b0}, ack);
        check("addr_ack", ack, match);
        if (match) begin
            check("busy_mid", busy, 1);
            write_byte(ra, ack);
            check("reg_ack", ack, 1);
            for (int i = 0; i < n; i++) begin
                write_byte(wbuf[i], ack);
                check("data_ack", ack, 1);
                exp_a[i]    = p;
                exp_d[i]    = wbuf[i];
                model_mem[p] = wbuf[i];
                if (AUTOINC)
                    p = p + 8'd1;
            end
        end
        bus_stop();
        check("busy_end", busy, 0);
        got = act_wr_n - wr0;
        check("wr_count", got, match ? n : 0);
        for (int i = 0; i < n && i < got; i++) begin
            check("wr_addr", act_wr_a[(wr0 + i) & 255], exp_a[i]);
            check("wr_data", act_wr_d[(wr0 + i) & 255], exp_d[i]);
        end
        if (match)
            check("ptr_after_wr", reg_addr, p);
        else
            check("no_sda_drive", dut_low_n - low0, 0);
    endtask

    task automatic i2c_read(input logic [7:0] ra, input int n);
        logic       ack;
        logic [7:0] d;
        logic [7:0] p;
        int         rd0;
        int         wr0;
        rd0 = rd_n;
        wr0 = act_wr_n;
        p   = ra;
        bus_start();
        write_byte({DEV, 1'b0}, ack);
        check("rd_addrw_ack", ack, 1);
        write_byte(ra, ack);
        check("rd_reg_ack", ack, 1);
        bus_rstart();
        write_byte({DEV, 1'b1}, ack);
        check("rd_addrr_ack", ack, 1);
        for (int i = 0; i < n; i++) begin
            read_byte(d, i < n - 1);
            check("rd_data", d, model_mem[p]);
            if (AUTOINC && i < n - 1)
                p = p + 8'd1;
        end
        wait_clk(6);
        check("sda_after_nack", sda_bus, 1);
        bus_stop();
        check("rd_count", rd_n - rd0, n);
        check("rd_no_write", act_wr_n - wr0, 0);
        check("ptr_after_rd", reg_addr, p);
        check("busy_end_rd", busy, 0);
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ack;
        logic [7:0] b8;
        logic [7:0] ra;
        int         wr0;
        int         kind;
        int         n;
        logic [6:0] bad;

        for (int i = 0; i < 256; i++)
            model_mem[i] = init_val(8'(i));

        rst = 1'b1;
        wait_clk(5);
        check("rst_reg_addr", reg_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_busy", busy, 0);
        check("rst_sda", sda_bus, 1);
        rst = 1'b0;
        wait_clk(5);

        wbuf[0] = 8'hA5;
        i2c_write(DEV, 8'h12, 1);

        i2c_read(8'h34, 1);

        wbuf[0] = 8'h99;
        i2c_write(7'h51, 8'h00, 1);

        wbuf[0] = 8'h11;
        wbuf[1] = 8'h22;
        wbuf[2] = 8'h33;
        i2c_write(DEV, 8'hFE, 3);

        // Repeated START cuts a data byte after four bits.
        wr0 = act_wr_n;
        bus_start();
        write_byte({DEV, 1'b0}, ack);
        write_byte(8'h20, ack);
        for (int i = 0; i < 4; i++)
            write_bit(1'($urandom));
        bus_rstart();
        write_byte({DEV, 1'b0}, ack);
        check("rs_addr_ack", ack, 1);
        write_byte(8'h40, ack);
        write_byte(8'h77, ack);
        bus_stop();
        model_mem[8'h40] = 8'h77;
        check("rs_wr_count", act_wr_n - wr0, 1);
        check("rs_wr_addr", act_wr_a[wr0 & 255], 8'h40);
        check("rs_wr_data", act_wr_d[wr0 & 255], 8'h77);

        // Reset while the address ACK is being driven.
        bus_start();
        b8 = {DEV, 1'b0};
        for (int i = 7; i >= 0; i--)
            write_bit(b8[i]);
        m_sda_low = 1'b0;
        wait_clk(6);
        check("ack_held_low", sda_bus, 0);
        rst = 1'b1;
        wait_clk(1);
        check("rst_mid_sda", sda_bus, 1);
        check("rst_mid_reg_addr", reg_addr, 0);
        check("rst_mid_wr_data", wr_data, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_wr_en", wr_en, 0);
        check("rst_mid_rd_en", rd_en, 0);
        rst = 1'b0;
        wait_clk(Q);
        bus_stop();
        wbuf[0] = 8'h5A;
        wbuf[1] = 8'hC3;
        i2c_write(DEV, 8'h60, 2);

        for (int t = 0; t < 20; t++) begin
            kind = int'($urandom_range(0, 3));
            n    = int'($urandom_range(1, 3));
            ra   = 8'($urandom);
            for (int i = 0; i < 4; i++)
                wbuf[i] = 8'($urandom);
            case (kind)
                0, 1: i2c_write(DEV, ra, n);
                2: i2c_read(ra, n);
                default: begin
                    bad = 7'($urandom);
                    if (bad == DEV)
                        bad = bad + 7'd1;
                    i2c_write(bad, ra, n);
                end
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
